cdb_arbiter: RTL

Round-robin arbiter that shares the single common data bus (CDB) among the completing functional units. It accepts at most one completion per cycle over valid/ready handshakes and registers it as the CDB broadcast packet. That packet drives the physical regfile write port and RS/ROB tag wakeup in the issue stage. It also drops completions killed by a branch mispredict and clears resolved branch bits from the broadcast mask.

---
 rtl/cdb_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  cdb_arbiter : round-robin arbiter granting one completion per cycle onto the
//                registered common data bus, with squash filtering and clear.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef PHYS_REGFILE_SIZE
`define PHYS_REGFILE_SIZE 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(`PHYS_REGFILE_SIZE),
    parameter int XLEN    = `XLEN,
    parameter int BMASK_W = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data,
    input  logic [NUM_REQ-1:0]                req_T_used,
    input  logic [NUM_REQ-1:0][BMASK_W-1:0]   req_bmask,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              squash_valid,
    input  logic                              clear_valid,
    input  logic [BMASK_W-1:0]                resolve_bit,
    output logic                              cdb_valid,
    output logic [TAG_W-1:0]                  cdb_tag,
    output logic [XLEN-1:0]                   cdb_data,
    output logic                              cdb_T_used,
    output logic [BMASK_W-1:0]                cdb_bmask
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic               win_found;
    logic [NUM_REQ-1:0] eligible;
    logic               handshake;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W:0]     cand;

    // A request that depends on the mispredicting branch is killed this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          !(squash_valid && (|(req_bmask[i] & resolve_bit)));
        end
    end

    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && eligible[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                winner    = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && win_found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign next_ptr  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_T_used <= 1'b0;
            cdb_bmask  <= '0;
        end else if (handshake) begin
            rr_ptr     <= next_ptr;
            cdb_valid  <= 1'b1;
            cdb_tag    <= req_tag[winner];
            cdb_data   <= req_data[winner];
            cdb_T_used <= req_T_used[winner];
            // A branch resolving correctly this cycle no longer guards the packet.
            cdb_bmask  <= req_bmask[winner] & ~(clear_valid ? resolve_bit : '0);
        end else begin
            cdb_valid  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
